// File: rtl/psc.sv
// Packet stream converter.
// Turns a strobed DATA_W-bit byte stream into a (DATA_W+1)-bit tagged stream.
// Bit DATA_W of each output word marks the last byte of a frame. A frame is a
// run of consecutive strobed cycles.
// Each accepted byte waits one cycle in a hold register, so the next cycle's
// strobe is known before the byte leaves. That strobe decides the end-of-frame
// flag, and the tagged word is then registered onto the outputs.
// Optional feature macro: PSC_MAXLEN_EN. When it is defined, frames are cut
// after MAX_LEN consecutive bytes.
module psc #(
    parameter int DATA_W  = 8,
    parameter int MAX_LEN = 16
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [DATA_W-1:0] iv_data,
    input  logic              i_data_wr,
    output logic [DATA_W:0]   ov_data,
    output logic              o_data_wr
);

    logic              hold_valid_reg;
    logic              hold_valid_next;
    logic [DATA_W-1:0] hold_data_reg;
    logic [DATA_W-1:0] hold_data_next;
    logic [DATA_W:0]   out_data_reg;
    logic [DATA_W:0]   out_data_next;
    logic              out_wr_reg;
    logic              out_wr_next;
    logic              last_flag;

`ifdef PSC_MAXLEN_EN
    localparam int CNT_W = $clog2(MAX_LEN + 1);

    // count_reg holds the number of bytes already emitted in the current frame.
    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;
    logic             at_max;

    assign at_max = (count_reg == CNT_W'(MAX_LEN - 1));

    // A held byte is last if no byte follows it, or if it fills the frame.
    always_comb begin
        last_flag = ~i_data_wr | at_max;
    end

    // Advance the frame length on every emit. Restart it after a flagged word.
    always_comb begin
        count_next = count_reg;
        if (hold_valid_reg) begin
            count_next = last_flag ? '0 : count_reg + CNT_W'(1);
        end
    end

    // Frame length register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end
`else
    // Frames are unbounded, so MAX_LEN has no effect in this build.
    logic unused_max_len;
    assign unused_max_len = (MAX_LEN != 0);

    // A held byte is last exactly when no byte follows it.
    always_comb begin
        last_flag = ~i_data_wr;
    end
`endif

    // Next hold contents, plus the tagged word built from the current hold.
    always_comb begin
        hold_valid_next = i_data_wr;
        hold_data_next  = i_data_wr ? iv_data : hold_data_reg;
        out_wr_next     = hold_valid_reg;
        out_data_next   = hold_valid_reg ? {last_flag, hold_data_reg} : '0;
    end

    // Hold register and output register. Reset discards any held byte.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            hold_valid_reg <= 1'b0;
            hold_data_reg  <= '0;
            out_wr_reg     <= 1'b0;
            out_data_reg   <= '0;
        end else begin
            hold_valid_reg <= hold_valid_next;
            hold_data_reg  <= hold_data_next;
            out_wr_reg     <= out_wr_next;
            out_data_reg   <= out_data_next;
        end
    end

    assign ov_data   = out_data_reg;
    assign o_data_wr = out_wr_reg;

endmodule

// File: tb/tb_psc.sv
// Testbench for psc.
// Directed frames and randomized traffic are checked against a stream-level
// reference model. The model tracks the previous cycle's input and the length
// of the current run of strobed cycles.
module tb_psc;

    localparam int DATA_W     = 8;
    localparam int TB_MAX_LEN = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic [DATA_W-1:0] iv_data = '0;
    logic              i_data_wr = 1'b0;
    logic [DATA_W:0]   ov_data;
    logic              o_data_wr;

    int compared   = 0;
    int mismatched = 0;

    // Reference model state.
    logic              prev_wr   = 1'b0;
    logic [DATA_W-1:0] prev_data = '0;
    int                prev_run  = 0;
    logic              exp_wr;
    logic [DATA_W:0]   exp_data;
    int                wr_cycles = 0;

    psc #(
        .DATA_W (DATA_W),
        .MAX_LEN(TB_MAX_LEN)
    ) dut (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .iv_data  (iv_data),
        .i_data_wr(i_data_wr),
        .ov_data  (ov_data),
        .o_data_wr(o_data_wr)
    );

    always #5 clk = ~clk;

    task automatic check_outputs(input string tag, input logic e_wr, input logic [DATA_W:0] e_data);
        compared++;
        assert (o_data_wr === e_wr)
        else begin
            mismatched++;
            $error("FAIL %s o_data_wr observed=%0b expected=%0b", tag, o_data_wr, e_wr);
        end
        compared++;
        assert (ov_data === e_data)
        else begin
            mismatched++;
            $error("FAIL %s ov_data observed=0x%03h expected=0x%03h", tag, ov_data, e_data);
        end
    endtask

    // Drive one cycle, then predict and check the word that follows the edge.
    // The byte from the previous cycle leaves now. It is last if this cycle
    // has no strobe, or (when bounded) if it completes a multiple of MAX_LEN.
    task automatic step(input string tag, input logic wr, input logic [DATA_W-1:0] d);
        logic last;
        i_data_wr = wr;
        iv_data   = d;
        @(posedge clk);
        #1;
        last = !wr;
`ifdef PSC_MAXLEN_EN
        if (prev_wr && (prev_run % TB_MAX_LEN == 0)) last = 1'b1;
`endif
        exp_wr   = prev_wr;
        exp_data = prev_wr ? {last, prev_data} : '0;
        if (o_data_wr === 1'b1) wr_cycles++;
        check_outputs(tag, exp_wr, exp_data);
        $display("step %-8s wr=%0b din=0x%02h -> o_wr=%0b out=0x%03h exp=0x%03h",
                 tag, wr, d, o_data_wr, ov_data, exp_data);
        prev_wr   = wr;
        prev_data = d;
        prev_run  = wr ? prev_run + 1 : 0;
    endtask

    // Assert reset away from a clock edge and confirm the outputs clear at once.
    // Hold reset for a few cycles, then release it away from an edge.
    task automatic do_reset(input string tag, input int cycles);
        i_data_wr = 1'b0;
        iv_data   = '0;
        rst_n     = 1'b0;
        #1;
        check_outputs(tag, 1'b0, '0);
        $display("reset %-8s o_wr=%0b out=0x%03h", tag, o_data_wr, ov_data);
        repeat (cycles) @(posedge clk);
        @(negedge clk);
        check_outputs({tag, "_held"}, 1'b0, '0);
        rst_n     = 1'b1;
        prev_wr   = 1'b0;
        prev_data = '0;
        prev_run  = 0;
        #2;
    endtask

    initial begin
        // Power-up reset, held until 100 ns.
        #2 rst_n = 1'b0;
        #1;
        check_outputs("por", 1'b0, '0);
        #97;
        check_outputs("por_end", 1'b0, '0);
        #2 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) step("idle0", 1'b0, 8'h00);

        // Burst 01..06, then idle.
        wr_cycles = 0;
        for (int i = 1; i <= 6; i++) step("burst1", 1'b1, 8'(i));
        for (int i = 0; i < 3; i++) step("tail1", 1'b0, 8'h00);
        compared++;
        assert (wr_cycles == 6)
        else begin
            mismatched++;
            $error("FAIL burst1_count observed=%0d expected=6", wr_cycles);
        end

        // Burst 07..0C, then idle.
        for (int i = 7; i <= 12; i++) step("burst2", 1'b1, 8'(i));
        for (int i = 0; i < 3; i++) step("tail2", 1'b0, 8'h00);

        // Single-byte frame.
        step("single", 1'b1, 8'hA5);
        for (int i = 0; i < 2; i++) step("tail3", 1'b0, 8'h00);

        // Reset mid-burst. The held byte must be discarded.
        for (int i = 0; i < 3; i++) step("preRst", 1'b1, 8'(8'h40 + i));
        do_reset("midRst", 3);
        step("after0", 1'b0, 8'h00);
        step("after1", 1'b1, 8'h33);
        for (int i = 0; i < 2; i++) step("tail4", 1'b0, 8'h00);

        // Long run spanning several MAX_LEN boundaries.
        for (int i = 0; i < 11; i++) step("long", 1'b1, 8'(8'h80 + i));
        step("tail5", 1'b0, 8'h00);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                do_reset("rndRst", $urandom_range(1, 3));
            end else begin
                step("rnd", ($urandom_range(0, 3) != 0), 8'($urandom));
            end
        end
        for (int i = 0; i < 3; i++) step("drain", 1'b0, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    // Absolute time bound so the run can never hang.
    initial begin
        #200000;
        $display("FAIL timeout simulation exceeded time bound");
        $fatal(1, "timeout");
    end

endmodule
